// File: rtl/seq_pkg.sv
// Shared definitions for the a[n] = a[n-2] + a[n-3] sequence generator/checker pair.
// Seed defaults live here so both ends of a link agree on the stream start.
package seq_pkg;

  typedef enum logic [1:0] {
    SEED,
    CHECK,
    HALT
  } seq_chk_state_e;

  localparam int unsigned NumSeeds = 3;
  localparam int unsigned DefSeed0 = 0;
  localparam int unsigned DefSeed1 = 1;
  localparam int unsigned DefSeed2 = 1;

endpackage

// File: rtl/seq_hist_reg.sv
// Three-deep sample history with the a[n-2] + a[n-3] adder; usable as a generator core by
// feeding sum_o back into din_i.
module seq_hist_reg
  import seq_pkg::*;
#(
  parameter int unsigned DataBus = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               shift_i,
  input  logic [DataBus-1:0] din_i,
  output logic [DataBus-1:0] sum_o
);

  logic [DataBus-1:0] h1_q, h2_q, h3_q;
  logic [DataBus-1:0] h1_d, h2_d, h3_d;

  always_comb begin
    h1_d = h1_q;
    h2_d = h2_q;
    h3_d = h3_q;
    if (clear_i) begin
      h1_d = '0;
      h2_d = '0;
      h3_d = '0;
    end else if (shift_i) begin
      h3_d = h2_q;
      h2_d = h1_q;
      h1_d = din_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1_q <= '0;
      h2_q <= '0;
      h3_q <= '0;
    end else begin
      h1_q <= h1_d;
      h2_q <= h2_d;
      h3_q <= h3_d;
    end
  end

  // Carry out is dropped: the recurrence wraps modulo 2^DataBus.
  assign sum_o = h2_q + h3_q;

endmodule

// File: rtl/seq_checker.sv
// Receive-side checker for the a[n] = a[n-2] + a[n-3] stream: flags per-sample mismatches,
// keeps a sticky error with first-error details and a saturating accepted-sample count.
module seq_checker
  import seq_pkg::*;
#(
  parameter int unsigned DataBus     = 32,
  parameter int unsigned CntW        = 16,
  parameter int unsigned SEED0       = DefSeed0,
  parameter int unsigned SEED1       = DefSeed1,
  parameter int unsigned SEED2       = DefSeed2,
  parameter bit          HALT_ON_ERR = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear_i,
  input  logic               seq_valid_i,
  input  logic [DataBus-1:0] seq_i,
  output logic               seq_ready_o,
  output logic               mismatch_o,
  output logic               err_o,
  output logic [CntW-1:0]    err_idx_o,
  output logic [DataBus-1:0] err_exp_o,
  output logic [DataBus-1:0] err_got_o,
  output logic [CntW-1:0]    cnt_o
);

  localparam logic [DataBus-1:0] Seed0 = DataBus'(SEED0);
  localparam logic [DataBus-1:0] Seed1 = DataBus'(SEED1);
  localparam logic [DataBus-1:0] Seed2 = DataBus'(SEED2);
  localparam logic [CntW-1:0]    CntMax = '1;

  seq_chk_state_e     state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               mismatch_q, mismatch_d;
  logic               err_q, err_d;
  logic [CntW-1:0]    err_idx_q, err_idx_d;
  logic [DataBus-1:0] err_exp_q, err_exp_d;
  logic [DataBus-1:0] err_got_q, err_got_d;

  logic               xfer;
  logic               is_mm;
  logic [DataBus-1:0] exp_val;
  logic [DataBus-1:0] hist_sum;

  // The history tracks received values, so one bad sample ripples into later expectations.
  seq_hist_reg #(
    .DataBus(DataBus)
  ) u_hist (
    .clk    (clk),
    .reset_n(reset_n),
    .clear_i(clear_i),
    .shift_i(xfer),
    .din_i  (seq_i),
    .sum_o  (hist_sum)
  );

  // Ready depends only on state, never on seq_valid_i.
  assign seq_ready_o = (state_q != HALT);
  assign xfer        = seq_valid_i & seq_ready_o & ~clear_i;

  always_comb begin
    exp_val = hist_sum;
    unique case (state_q)
      SEED: begin
        if (cnt_q == CntW'(0)) begin
          exp_val = Seed0;
        end else if (cnt_q == CntW'(1)) begin
          exp_val = Seed1;
        end else begin
          exp_val = Seed2;
        end
      end
      CHECK, HALT: exp_val = hist_sum;
      default:     exp_val = hist_sum;
    endcase
  end

  assign is_mm = (seq_i != exp_val);

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = SEED;
    end else if (xfer) begin
      if ((state_q == SEED) && (cnt_q == CntW'(NumSeeds - 1))) begin
        state_d = CHECK;
      end
      if (HALT_ON_ERR && is_mm) begin
        state_d = HALT;
      end
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    if (clear_i) begin
      cnt_d     = '0;
      err_d     = 1'b0;
      err_idx_d = '0;
      err_exp_d = '0;
      err_got_d = '0;
    end else if (xfer) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntW'(1);
      end
      mismatch_d = is_mm;
      // Only the first mismatch is latched; later ones just pulse.
      if (is_mm && !err_q) begin
        err_d     = 1'b1;
        err_idx_d = cnt_q;
        err_exp_d = exp_val;
        err_got_d = seq_i;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SEED;
      cnt_q      <= '0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
    end
  end

  assign mismatch_o = mismatch_q;
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;
  assign err_exp_o  = err_exp_q;
  assign err_got_o  = err_got_q;
  assign cnt_o      = cnt_q;

endmodule

// File: tb/tb_seq_checker.sv
// Randomised scoreboard bench for seq_checker: three configurations (32-bit, 8-bit with a
// 3-bit counter, halt-on-error) against a list-based model of the recurrence.
module tb_seq_checker;
  import seq_pkg::*;

  typedef struct {
    bit          mm;
    bit          err;
    int unsigned cnt;
    int unsigned eidx;
    logic [31:0] eexp;
    logic [31:0] egot;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vld, clr;
  logic [31:0] din;
  int          sel;

  always #5 clk = ~clk;

  // Instance 0: default 32-bit, no halt.
  logic r0, m0, e0;
  logic [15:0] i0, c0;
  logic [31:0] x0, g0;
  // Instance 1: 8-bit data, 3-bit counter.
  logic r1, m1, e1;
  logic [2:0] i1, c1;
  logic [7:0] x1, g1;
  // Instance 2: halt on error.
  logic r2, m2, e2;
  logic [15:0] i2, c2;
  logic [31:0] x2, g2;

  seq_checker #(.DataBus(32), .CntW(16), .HALT_ON_ERR(1'b0)) u_d32 (
    .clk(clk), .reset_n(reset_n), .clear_i(clr && sel == 0), .seq_valid_i(vld && sel == 0),
    .seq_i(din), .seq_ready_o(r0), .mismatch_o(m0), .err_o(e0), .err_idx_o(i0),
    .err_exp_o(x0), .err_got_o(g0), .cnt_o(c0)
  );

  seq_checker #(.DataBus(8), .CntW(3), .HALT_ON_ERR(1'b0)) u_d8 (
    .clk(clk), .reset_n(reset_n), .clear_i(clr && sel == 1), .seq_valid_i(vld && sel == 1),
    .seq_i(din[7:0]), .seq_ready_o(r1), .mismatch_o(m1), .err_o(e1), .err_idx_o(i1),
    .err_exp_o(x1), .err_got_o(g1), .cnt_o(c1)
  );

  seq_checker #(.DataBus(32), .CntW(16), .HALT_ON_ERR(1'b1)) u_dh (
    .clk(clk), .reset_n(reset_n), .clear_i(clr && sel == 2), .seq_valid_i(vld && sel == 2),
    .seq_i(din), .seq_ready_o(r2), .mismatch_o(m2), .err_o(e2), .err_idx_o(i2),
    .err_exp_o(x2), .err_got_o(g2), .cnt_o(c2)
  );

  logic        rdy, mmo, erro;
  logic [31:0] idxo, cnto, expo, goto;

  always_comb begin
    rdy = r0; mmo = m0; erro = e0; idxo = 32'(i0); cnto = 32'(c0); expo = x0; goto = g0;
    case (sel)
      1: begin
        rdy = r1; mmo = m1; erro = e1; idxo = 32'(i1); cnto = 32'(c1);
        expo = 32'(x1); goto = 32'(g1);
      end
      2: begin
        rdy = r2; mmo = m2; erro = e2; idxo = 32'(i2); cnto = 32'(c2); expo = x2; goto = g2;
      end
      default: ;
    endcase
  end

  int          n_chk = 0, n_fail = 0;
  exp_t        q[$];
  int unsigned m_n;
  logic [31:0] m_rx[$];
  bit          m_err, m_halt;
  int unsigned m_eidx;
  logic [31:0] m_eexp, m_egot;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (sel %0d, t=%0t)", name, act, req, sel, $time);
    end
  endtask

  function automatic logic [31:0] mask();
    return (sel == 1) ? 32'hFF : 32'hFFFF_FFFF;
  endfunction

  function automatic int unsigned cnt_max();
    return (sel == 1) ? 7 : 65535;
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v > cnt_max()) ? cnt_max() : v;
  endfunction

  // Ideal stream element n, built directly from the recurrence.
  function automatic logic [31:0] good_val(input int n);
    logic [31:0] a[$];
    a = {32'(DefSeed0), 32'(DefSeed1), 32'(DefSeed2)};
    for (int k = 3; k <= n; k++) a.push_back((a[k-2] + a[k-3]) & mask());
    return a[n] & mask();
  endfunction

  task automatic model_clear();
    m_n = 0; m_rx.delete(); m_err = 0; m_halt = 0; m_eidx = 0; m_eexp = 0; m_egot = 0;
  endtask

  task automatic model_step(input logic [31:0] v);
    logic [31:0] e, got;
    bit          mm;
    exp_t        r;
    got = v & mask();
    if (m_n == 0)      e = 32'(DefSeed0);
    else if (m_n == 1) e = 32'(DefSeed1);
    else if (m_n == 2) e = 32'(DefSeed2);
    else               e = (m_rx[m_n-2] + m_rx[m_n-3]) & mask();
    mm = (got != e);
    if (mm && !m_err) begin
      m_err = 1; m_eidx = sat(m_n); m_eexp = e; m_egot = got;
    end
    if (mm && sel == 2) m_halt = 1;
    m_rx.push_back(got);
    m_n++;
    r.mm = mm; r.err = m_err; r.cnt = sat(m_n); r.eidx = m_eidx; r.eexp = m_eexp;
    r.egot = m_egot;
    q.push_back(r);
  endtask

  task automatic send(input logic [31:0] v, input bit valid, input bit c);
    @(negedge clk);
    #1;
    chk("ready", 32'(rdy), 32'(!m_halt));
    vld = valid; din = v; clr = c;
    if (c) model_clear();
    else if (valid && !m_halt) model_step(v);
  endtask

  task automatic idle();
    send(32'($urandom), 1'b0, 1'b0);
  endtask

  // Monitor: a transfer seen before an edge must be reflected in outputs after it.
  initial begin
    bit   pend;
    exp_t e;
    pend = 0;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_underflow: transfer seen with no expected entry (t=%0t)", $time);
        end else begin
          e = q.pop_front();
          chk("mismatch", 32'(mmo), 32'(e.mm));
          chk("err", 32'(erro), 32'(e.err));
          chk("cnt", cnto, e.cnt);
          chk("err_idx", idxo, e.eidx);
          chk("err_exp", expo, e.eexp);
          chk("err_got", goto, e.egot);
        end
      end else begin
        chk("idle_mismatch", 32'(mmo), 32'd0);
      end
      #2;
      pend = vld && rdy && !clr && reset_n;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 0; vld = 0; clr = 0; din = 0; sel = 0;
    model_clear();
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      chk("rst_ready", 32'(rdy), 32'd1);
      chk("rst_cnt", cnto, 32'd0);
      chk("rst_err", 32'(erro), 32'd0);
      chk("rst_mm", 32'(mmo), 32'd0);
    end
    sel = 0;
    #5 reset_n = 1;

    // 1: clean stream.
    for (int k = 0; k < 12; k++) send(good_val(k), 1'b1, 1'b0);
    idle(); idle();
    chk("t1_cnt", cnto, 32'd12);
    chk("t1_err", 32'(erro), 32'd0);

    // 2: a[6] corrupted to 4.
    send(0, 1'b0, 1'b1);
    for (int k = 0; k < 12; k++) send((k == 6) ? 32'd4 : good_val(k), 1'b1, 1'b0);
    idle(); idle();
    chk("t2_err", 32'(erro), 32'd1);
    chk("t2_idx", idxo, 32'd6);
    chk("t2_exp", expo, 32'd3);
    chk("t2_got", goto, 32'd4);

    // 3: 8-bit wrap, counter saturation, late error index saturates.
    sel = 1;
    send(0, 1'b0, 1'b1);
    for (int k = 0; k < 26; k++) send(good_val(k), 1'b1, 1'b0);
    idle();
    chk("t3_err_clean", 32'(erro), 32'd0);
    chk("t3_cnt_sat", cnto, 32'd7);
    send(good_val(26) ^ 32'h1, 1'b1, 1'b0);
    idle(); idle();
    chk("t3_idx_sat", idxo, 32'd7);

    // 4: halt on error at n=4, then clear and restart.
    sel = 2;
    send(0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send(good_val(k), 1'b1, 1'b0);
    send(32'd99, 1'b1, 1'b0);
    for (int k = 5; k < 8; k++) send(good_val(k), 1'b1, 1'b0);
    idle();
    chk("t4_halt_ready", 32'(rdy), 32'd0);
    chk("t4_cnt", cnto, 32'd5);
    send(0, 1'b0, 1'b1);
    idle();
    chk("t4_clr_cnt", cnto, 32'd0);
    for (int k = 0; k < 6; k++) send(good_val(k), 1'b1, 1'b0);
    idle(); idle();
    chk("t4_restart_err", 32'(erro), 32'd0);

    // 5: random valid gaps, then clear colliding with a valid sample.
    sel = 0;
    send(0, 1'b0, 1'b1);
    n = 0;
    while (n < 30) begin
      if ($urandom_range(0, 2) == 0) idle();
      else begin
        send(good_val(n), 1'b1, 1'b0);
        n++;
      end
    end
    idle(); idle();
    chk("t5_cnt", cnto, 32'd30);
    chk("t5_err", 32'(erro), 32'd0);
    send(good_val(30), 1'b1, 1'b1);
    idle();
    chk("t5_clr_cnt", cnto, 32'd0);
    for (int k = 0; k < 3; k++) send(good_val(k), 1'b1, 1'b0);
    for (int k = 3; k < 8; k++) send((k == 5) ? 32'hDEAD : good_val(k), 1'b1, 1'b0);
    idle(); idle();
    chk("t6_pre_err", 32'(erro), 32'd1);

    // 6: asynchronous reset between edges.
    @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_err", 32'(erro), 32'd0);
    chk("t6_rst_cnt", cnto, 32'd0);
    chk("t6_rst_idx", idxo, 32'd0);
    chk("t6_rst_ready", 32'(rdy), 32'd1);
    model_clear();
    q.delete();
    @(negedge clk);
    #3 reset_n = 1;
    for (int k = 0; k < 6; k++) send(good_val(k), 1'b1, 1'b0);
    idle(); idle();
    chk("t6_restart_cnt", cnto, 32'd6);
    chk("t6_restart_err", 32'(erro), 32'd0);
    chk("sb_drain", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
